// File: rtl/norm_ctrl_if.sv
// norm_ctrl_if: requester handshake plus shift-register control bundle for norm_ctrl.
// The zero flag exists only when NORM_CTRL_ZERO_DET_EN is defined.
interface norm_ctrl_if #(parameter int WIDTH = 8);
  localparam int CW = $clog2(WIDTH);
  logic start, msb_in, ready, load, shift_en, in_sh, done;
  logic [CW-1:0] shamt;
`ifdef NORM_CTRL_ZERO_DET_EN
  logic zero;
  modport master (output start, msb_in, input ready, load, shift_en, in_sh, shamt, done, zero);
  modport slave (input start, msb_in, output ready, load, shift_en, in_sh, shamt, done, zero);
`else
  modport master (output start, msb_in, input ready, load, shift_en, in_sh, shamt, done);
  modport slave (input start, msb_in, output ready, load, shift_en, in_sh, shamt, done);
`endif
endinterface

// File: rtl/norm_ctrl.sv
// norm_ctrl: left-normalises an external shift register and reports the shift count.
// NORM_CTRL_ZERO_DET_EN adds a zero flag and reports shamt=0 for an all-zero operand.
module norm_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  norm_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef NORM_CTRL_ZERO_DET_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, shamt_q, shamt_d;
  logic last, zero_d, shift_en;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shamt_d = shamt_q;
    zero_d = 1'b0;
    shift_en = 1'b0;
    last = count_q == CW'(WIDTH - 1);
    case (state_q)
      IDLE: state_d = bus.start ? LOAD : IDLE;
      LOAD: begin
        count_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Stop on a set MSB, or after WIDTH-1 shifts when the operand is all zero
        if (bus.msb_in || last) begin
          state_d = DONE;
          zero_d = !bus.msb_in;
          shamt_d = (ZD && zero_d) ? '0 : count_q;
        end else begin
          shift_en = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shamt_q <= shamt_d;
    end
  end
`ifdef NORM_CTRL_ZERO_DET_EN
  logic zero_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) zero_q <= 1'b0;
    else zero_q <= zero_d;
  end
  assign bus.zero = zero_q;
`endif
  assign bus.ready = state_q == IDLE;
  assign bus.load = state_q == LOAD;
  assign bus.done = state_q == DONE;
  assign bus.shift_en = shift_en;
  assign bus.in_sh = 1'b0;
  assign bus.shamt = shamt_q;
endmodule

// File: tb/tb_norm_ctrl.sv
// tb_norm_ctrl: scoreboard bench for norm_ctrl driving a behavioural 8-bit shift register.
module tb_norm_ctrl;
  typedef struct {logic [2:0] shamt; logic zero; logic [7:0] regv; int lat;} exp_t;
  logic clk = 0, rst = 1;
  logic [7:0] sr = 0, opnd = 0;
  int vectors = 0, miscompares = 0, cyc = 0, c0 = 0, done_cnt = 0, n_issued = 0;
  bit overlap = 0;
  exp_t q[$];
  norm_ctrl_if #(.WIDTH(8)) bus();
  norm_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.load) sr <= opnd;
    else if (bus.shift_en) sr <= {sr[6:0], bus.in_sh};
  end
  assign bus.msb_in = sr[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] op, input int k);
    exp_t e;
`ifdef NORM_CTRL_ZERO_DET_EN
    e.shamt = (op == 8'h00) ? 3'd0 : 3'(k);
    e.zero = op == 8'h00;
`else
    e.shamt = 3'(k);
    e.zero = 1'b0;
`endif
    e.regv = op << k;
    e.lat = 3 + k;
    return e;
  endfunction

  function automatic int lzc(input logic [7:0] op);
    for (int i = 7; i >= 1; i--) if (op[i]) return 7 - i;
    return 7;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.load && bus.shift_en) overlap = 1;
    if (rst && bus.ready && bus.start) c0 = cyc;
    if (rst && bus.done) begin
      done_cnt++;
      if (q.size() == 0) check("spurious_done", q.size(), 1);
      else begin
        e = q.pop_front();
        check("shamt", bus.shamt, e.shamt);
        check("reg_out", sr, e.regv);
        check("latency", cyc - c0, e.lat);
`ifdef NORM_CTRL_ZERO_DET_EN
        check("zero", bus.zero, e.zero);
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #2;
    while (!bus.ready && n < 60) begin @(posedge clk); #2; n++; end
    if (!bus.ready) check("ready_wait", bus.ready, 1);
  endtask

  task automatic run_op(input logic [7:0] op, input int k);
    wait_ready();
    opnd = op;
    bus.start = 1;
    q.push_back(mk(op, k));
    n_issued++;
    @(posedge clk); #2;
    bus.start = 0;
    wait_ready();
  endtask

  logic [7:0] dir_op [11] = '{8'h80, 8'h01, 8'h00, 8'hff, 8'h3c, 8'h20, 8'h08, 8'h04, 8'h40, 8'h02, 8'h11};
  int dir_k [11] = '{0, 7, 7, 0, 2, 2, 4, 5, 1, 6, 3};

  initial begin
    bit ready_bad;
    int dc, j;
    logic [7:0] r;
    bus.start = 0;
    #3 rst = 0;
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_load", bus.load, 0);
    check("rst_shift_en", bus.shift_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_shamt", bus.shamt, 0);
`ifdef NORM_CTRL_ZERO_DET_EN
    check("rst_zero", bus.zero, 0);
`endif
    #8 rst = 1;
    for (int i = 0; i < 11; i++) run_op(dir_op[i], dir_k[i]);
    // start held high, dropped and re-raised mid-shift: one operation only
    wait_ready();
    opnd = 8'h10;
    bus.start = 1;
    q.push_back(mk(8'h10, 3));
    n_issued++;
    dc = done_cnt;
    ready_bad = 0;
    j = 0;
    do begin
      @(posedge clk); #2;
      if (bus.ready) ready_bad = 1;
      if (j == 2) bus.start = 0;
      if (j == 3) bus.start = 1;
      j++;
    end while (!bus.done && j < 30);
    bus.start = 0;
    check("held_done_seen", bus.done, 1);
    check("held_ready_low", ready_bad, 0);
    check("held_shamt_stable", bus.shamt, 3);
    wait_ready();
    repeat (4) @(posedge clk);
    check("held_one_done", done_cnt - dc, 1);
    // reset during third shift cycle of 0x02
    wait_ready();
    opnd = 8'h02;
    bus.start = 1;
    dc = done_cnt;
    @(posedge clk); #2;
    bus.start = 0;
    repeat (3) begin @(posedge clk); #2; end
    check("mid_shift_en", bus.shift_en, 1);
    rst = 0;
    #1;
    check("abort_ready", bus.ready, 1);
    check("abort_shift_en", bus.shift_en, 0);
    check("abort_load", bus.load, 0);
    check("abort_done", bus.done, 0);
    check("abort_shamt", bus.shamt, 0);
    @(posedge clk); #2;
    rst = 1;
    repeat (20) @(posedge clk);
    check("abort_no_done", done_cnt - dc, 0);
    run_op(8'h40, 1);
    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom_range(0, 255));
      run_op(r, lzc(r));
    end
    repeat (4) @(posedge clk);
    check("overlap", overlap, 0);
    check("done_count", done_cnt, n_issued);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
